// File: rtl/min_search_pkg.sv
// Shared definitions for the minimum-SAD search controller: FSM encoding and default sizing.
package min_search_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWait,
        StCmp,
        StDone
    } state_e;

    localparam int unsigned NUM_CORES_DEF   = 8;
    localparam int unsigned SAD_W_DEF       = 32;
    localparam int unsigned POS_W_DEF       = 6;
    localparam int unsigned SEARCH_ROWS_DEF = 8;
    localparam int unsigned SEARCH_COLS_DEF = 8;
    localparam int unsigned MIN_INIT_DEF    = 100000;

endpackage

// File: rtl/core_valid_collector.sv
// Gathers per-core result pulses for one batch: sticky valid mask plus a SAD capture slot per core.
module core_valid_collector
    import min_search_pkg::*;
#(
    parameter int unsigned NUM_CORES = NUM_CORES_DEF,
    parameter int unsigned SAD_W     = SAD_W_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       capture,
    input  logic [NUM_CORES-1:0]       inactive,
    input  logic [NUM_CORES-1:0]       valid,
    input  logic [NUM_CORES*SAD_W-1:0] sad_in,
    output logic [NUM_CORES*SAD_W-1:0] sad_slots,
    output logic [NUM_CORES-1:0]       mask,
    output logic                       all_done
);

    logic [NUM_CORES-1:0]       mask_q;
    logic [NUM_CORES*SAD_W-1:0] slots_q;
    logic [NUM_CORES-1:0]       hit;

    // Pulses from inactive cores or outside the capture window never reach the slots.
    assign hit = valid & ~inactive & {NUM_CORES{capture}};

    always_ff @(posedge clk) begin
        if (rst) begin
            mask_q  <= '0;
            slots_q <= '0;
        end else if (clear) begin
            mask_q <= '0;
        end else begin
            mask_q <= mask_q | hit;
            for (int k = 0; k < NUM_CORES; k++) begin
                if (hit[k]) begin
                    slots_q[k*SAD_W +: SAD_W] <= sad_in[k*SAD_W +: SAD_W];
                end
            end
        end
    end

    // Includes this cycle's pulses so the batch can close in the same cycle the last one lands.
    assign all_done  = &(mask_q | hit | inactive);
    assign mask      = mask_q;
    assign sad_slots = slots_q;

endmodule

// File: rtl/min_search_controller.sv
// Full-search minimum-SAD sequencer: issues raster-ordered candidate batches to parallel SAD
// cores, collects their results and tracks the running minimum and its position.
module min_search_controller
    import min_search_pkg::*;
#(
    parameter int unsigned NUM_CORES   = NUM_CORES_DEF,
    parameter int unsigned SAD_W       = SAD_W_DEF,
    parameter int unsigned POS_W       = POS_W_DEF,
    parameter int unsigned SEARCH_ROWS = SEARCH_ROWS_DEF,
    parameter int unsigned SEARCH_COLS = SEARCH_COLS_DEF,
    parameter int unsigned MIN_INIT    = MIN_INIT_DEF
) (
    input  logic                       Clk,
    input  logic                       Rst,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    output logic [NUM_CORES-1:0]       core_go,
    output logic [NUM_CORES*POS_W-1:0] core_row,
    output logic [NUM_CORES*POS_W-1:0] core_col,
    input  logic [NUM_CORES*SAD_W-1:0] core_sad,
    input  logic [NUM_CORES-1:0]       core_valid,
    output logic [SAD_W-1:0]           min_out,
    output logic [2*POS_W-1:0]         row_col_out
);

    localparam int unsigned TOTAL = SEARCH_ROWS * SEARCH_COLS;
    localparam int unsigned IDX_W = 2 * POS_W + 2;
    localparam int unsigned CNT_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    state_e                     state_q, state_d;
    logic [IDX_W-1:0]           idx_q, idx_d;
    logic [POS_W-1:0]           brow_q, bcol_q;
    logic [POS_W-1:0]           next_brow, next_bcol;
    logic [CNT_W-1:0]           k_q, k_d;
    logic [SAD_W-1:0]           min_q, min_d;
    logic [2*POS_W-1:0]         rc_q, rc_d;
    logic [NUM_CORES*POS_W-1:0] row_q, col_q, row_nxt, col_nxt;
    logic                       load_pos, clear, capture;
    logic [NUM_CORES-1:0]       active, mask;
    logic [NUM_CORES*SAD_W-1:0] sad_slots;
    logic                       all_done;
    logic [SAD_W-1:0]           sad_sel;
    logic [POS_W-1:0]           row_sel, col_sel;

    // Candidate positions for the batch about to be issued, stepped core by core in raster order.
    // The trailing step yields the first position of the batch after it.
    always_comb begin
        logic [POS_W-1:0] r, c;
        r = (state_q == StIdle) ? '0 : brow_q;
        c = (state_q == StIdle) ? '0 : bcol_q;
        row_nxt = '0;
        col_nxt = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            row_nxt[k*POS_W +: POS_W] = r;
            col_nxt[k*POS_W +: POS_W] = c;
            if (c == POS_W'(SEARCH_COLS - 1)) begin
                r = r + 1'b1;
                c = '0;
            end else begin
                c = c + 1'b1;
            end
        end
        next_brow = r;
        next_bcol = c;
    end

    always_comb begin
        for (int k = 0; k < NUM_CORES; k++) begin
            active[k] = (idx_q + IDX_W'(k)) < IDX_W'(TOTAL);
        end
    end

    core_valid_collector #(
        .NUM_CORES (NUM_CORES),
        .SAD_W     (SAD_W)
    ) u_collector (
        .clk       (Clk),
        .rst       (Rst),
        .clear     (clear),
        .capture   (capture),
        .inactive  (~active),
        .valid     (core_valid),
        .sad_in    (core_sad),
        .sad_slots (sad_slots),
        .mask      (mask),
        .all_done  (all_done)
    );

    assign sad_sel = sad_slots[k_q*SAD_W +: SAD_W];
    assign row_sel = row_q[k_q*POS_W +: POS_W];
    assign col_sel = col_q[k_q*POS_W +: POS_W];

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        k_d      = k_q;
        min_d    = min_q;
        rc_d     = rc_q;
        load_pos = 1'b0;
        clear    = 1'b0;
        capture  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    min_d    = SAD_W'(MIN_INIT);
                    rc_d     = '0;
                    idx_d    = '0;
                    load_pos = 1'b1;
                    state_d  = StIssue;
                end
            end
            StIssue: begin
                clear   = 1'b1;
                k_d     = '0;
                state_d = StWait;
            end
            StWait: begin
                capture = 1'b1;
                if (all_done) begin
                    state_d = StCmp;
                end
            end
            StCmp: begin
                // Strict compare: on a tie the earlier raster index is kept.
                if (active[k_q] && (sad_sel < min_q)) begin
                    min_d = sad_sel;
                    rc_d  = {row_sel, col_sel};
                end
                if (k_q == CNT_W'(NUM_CORES - 1)) begin
                    if ((idx_q + IDX_W'(NUM_CORES)) >= IDX_W'(TOTAL)) begin
                        state_d = StDone;
                    end else begin
                        idx_d    = idx_q + IDX_W'(NUM_CORES);
                        load_pos = 1'b1;
                        state_d  = StIssue;
                    end
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= StIdle;
            idx_q   <= '0;
            brow_q  <= '0;
            bcol_q  <= '0;
            k_q     <= '0;
            min_q   <= SAD_W'(MIN_INIT);
            rc_q    <= '0;
            row_q   <= '0;
            col_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            k_q     <= k_d;
            min_q   <= min_d;
            rc_q    <= rc_d;
            if (load_pos) begin
                row_q  <= row_nxt;
                col_q  <= col_nxt;
                brow_q <= next_brow;
                bcol_q <= next_bcol;
            end
        end
    end

    assign busy        = (state_q != StIdle);
    assign done        = (state_q == StDone);
    assign core_go     = (state_q == StIssue) ? active : '0;
    assign core_row    = row_q;
    assign core_col    = col_q;
    assign min_out     = min_q;
    assign row_col_out = rc_q;

endmodule

// File: tb/tb_min_search_controller.sv
// Self-checking bench: an 8x8 and a 3x3 controller driven by a core-response model, results
// checked against a plain minimum search over the SAD table.
module tb_min_search_controller;

    localparam int N = 8;
    localparam int W = 32;
    localparam int P = 6;
    localparam int MIN_INIT = 100000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start_a = 1'b0;
    logic start_b = 1'b0;
    logic [N-1:0]   valid = '0;
    logic [N*W-1:0] sad_bus = '0;

    logic           busy_a, done_a, busy_b, done_b;
    logic [N-1:0]   go_a, go_b;
    logic [N*P-1:0] row_a, col_a, row_b, col_b;
    logic [W-1:0]   min_a, min_b;
    logic [2*P-1:0] rc_a, rc_b;

    always #5 clk = ~clk;

    min_search_controller u_dut_a (
        .Clk (clk), .Rst (rst), .start (start_a), .busy (busy_a), .done (done_a),
        .core_go (go_a), .core_row (row_a), .core_col (col_a), .core_sad (sad_bus),
        .core_valid (valid), .min_out (min_a), .row_col_out (rc_a)
    );

    min_search_controller #(.SEARCH_ROWS (3), .SEARCH_COLS (3)) u_dut_b (
        .Clk (clk), .Rst (rst), .start (start_b), .busy (busy_b), .done (done_b),
        .core_go (go_b), .core_row (row_b), .core_col (col_b), .core_sad (sad_bus),
        .core_valid (valid), .min_out (min_b), .row_col_out (rc_b)
    );

    logic           sel = 1'b0;
    logic           busy_s, done_s;
    logic [N-1:0]   go_s;
    logic [N*P-1:0] row_s, col_s;
    logic [W-1:0]   min_s;
    logic [2*P-1:0] rc_s;
    assign busy_s = sel ? busy_b : busy_a;
    assign done_s = sel ? done_b : done_a;
    assign go_s   = sel ? go_b : go_a;
    assign row_s  = sel ? row_b : row_a;
    assign col_s  = sel ? col_b : col_a;
    assign min_s  = sel ? min_b : min_a;
    assign rc_s   = sel ? rc_b : rc_a;

    int          n_cmp = 0;
    int          n_fail = 0;
    int          cols_cur = 8;
    int          total_cur = 64;
    int unsigned tab [64];
    int          dly [N];
    bit          junk = 1'b0;
    int          batch = 0;
    int          cnt [N];
    int unsigned val [N];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Core model: each launched core answers dly[k] cycles after its go pulse with tab[idx].
    // With junk set, cores left idle in a batch answer too, with SAD 0.
    always @(negedge clk) begin
        logic [N-1:0] em;
        valid = '0;
        if (rst || !busy_s) begin
            batch = 0;
            for (int k = 0; k < N; k++) cnt[k] = 0;
        end else begin
            for (int k = 0; k < N; k++) begin
                if (cnt[k] > 0) begin
                    cnt[k]--;
                    if (cnt[k] == 0) begin
                        valid[k] = 1'b1;
                        sad_bus[k*W +: W] = val[k];
                    end
                end
            end
            if (go_s != '0) begin
                for (int k = 0; k < N; k++) em[k] = (batch * N + k) < total_cur;
                chk("core_go", go_s, em);
                for (int k = 0; k < N; k++) begin
                    int idx;
                    idx = batch * N + k;
                    if (em[k]) begin
                        chk("core_row", row_s[k*P +: P], idx / cols_cur);
                        chk("core_col", col_s[k*P +: P], idx % cols_cur);
                        cnt[k] = dly[k];
                        val[k] = tab[idx];
                    end else if (junk) begin
                        cnt[k] = dly[k];
                        val[k] = 0;
                    end
                end
                batch++;
            end
        end
    end

    task automatic set_start(input bit use_b, input logic v);
        if (use_b) start_b = v;
        else start_a = v;
    endtask

    task automatic run_scan(input bit use_b, input int mid_start, input string tag);
        int unsigned emin;
        int erc, lat, cyc, nb;
        sel       = use_b;
        cols_cur  = use_b ? 3 : 8;
        total_cur = use_b ? 9 : 64;
        emin = MIN_INIT;
        erc  = 0;
        for (int i = 0; i < total_cur; i++) begin
            if (tab[i] < emin) begin
                emin = tab[i];
                erc  = ((i / cols_cur) << P) | (i % cols_cur);
            end
        end
        nb  = (total_cur + N - 1) / N;
        lat = 1;
        for (int b = 0; b < nb; b++) begin
            int md = 0;
            for (int k = 0; k < N; k++) if (b * N + k < total_cur && dly[k] > md) md = dly[k];
            lat += N + 1 + md;
        end
        @(negedge clk);
        set_start(use_b, 1'b1);
        cyc = 0;
        @(negedge clk);
        cyc = 1;
        set_start(use_b, 1'b0);
        chk({tag, "_busy_after_start"}, busy_s, 1);
        while (!done_s && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            set_start(use_b, cyc == mid_start);
        end
        set_start(use_b, 1'b0);
        chk({tag, "_done_seen"}, done_s, 1);
        chk({tag, "_latency"}, cyc, lat);
        chk({tag, "_min"}, min_s, emin);
        chk({tag, "_row_col"}, rc_s, erc);
        @(negedge clk);
        chk({tag, "_done_pulse"}, done_s, 0);
        chk({tag, "_busy_end"}, busy_s, 0);
        chk({tag, "_min_hold"}, min_s, emin);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_busy"}, busy_a, 0);
        chk({tag, "_done"}, done_a, 0);
        chk({tag, "_go"}, go_a, 0);
        chk({tag, "_row"}, row_a, 0);
        chk({tag, "_col"}, col_a, 0);
        chk({tag, "_min"}, min_a, MIN_INIT);
        chk({tag, "_rc"}, rc_a, 0);
    endtask

    task automatic fill_scn2();
        for (int i = 0; i < 64; i++) tab[i] = i + 50;
        tab[37] = 5;
        for (int k = 0; k < N; k++) dly[k] = 1;
    endtask

    initial begin
        int guard;
        for (int k = 0; k < N; k++) begin
            dly[k] = 1;
            cnt[k] = 0;
            val[k] = 0;
        end

        // Reset held two cycles
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk_reset("reset");
        chk("reset_b_min", min_b, MIN_INIT);
        rst = 1'b0;

        // Single strong minimum, all cores answer one cycle after go
        fill_scn2();
        run_scan(1'b0, 0, "scan_basic");

        // Equal minima at idx 9 and 40: earlier one wins
        for (int i = 0; i < 64; i++) tab[i] = 99;
        tab[9]  = 20;
        tab[40] = 20;
        run_scan(1'b0, 0, "ties");

        // Nothing below the initial minimum, including an exact equal
        for (int i = 0; i < 64; i++) tab[i] = MIN_INIT + $urandom_range(0, 5000);
        tab[20] = MIN_INIT;
        run_scan(1'b0, 0, "above_init");

        // 3x3 search: partial second batch, idle cores answering with SAD 0
        junk = 1'b1;
        for (int i = 0; i < 64; i++) tab[i] = $urandom_range(10, 1000);
        run_scan(1'b1, 0, "partial");

        // Out-of-order late answers plus a stray start mid-scan
        junk = 1'b0;
        for (int i = 0; i < 64; i++) tab[i] = $urandom_range(0, 5000);
        for (int k = 0; k < N; k++) dly[k] = $urandom_range(2, 6);
        dly[7] = 1;
        dly[0] = 21;
        run_scan(1'b0, 30, "late_valid");

        // Randomised scans on both geometries
        for (int r = 0; r < 6; r++) begin
            junk = (r % 2 == 1);
            for (int i = 0; i < 64; i++) tab[i] = $urandom_range(0, 150000);
            for (int k = 0; k < N; k++) dly[k] = $urandom_range(1, 4);
            run_scan(r >= 4, 0, "random");
        end
        junk = 1'b0;

        // Reset in the middle of the third batch's wait, then a clean rerun
        sel = 1'b0;
        cols_cur = 8;
        total_cur = 64;
        for (int i = 0; i < 64; i++) tab[i] = i + 7;
        for (int k = 0; k < N; k++) dly[k] = 6;
        @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        guard = 0;
        while (batch < 3 && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        chk("midrst_reached_batch3", batch, 3);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_reset("midrst");
        rst = 1'b0;
        fill_scn2();
        run_scan(1'b0, 0, "after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
